trap_dump: RTL and testbench

TRAP_DUMP -- requirements
Module: trap_dump

---
 rtl/trap_dump_pkg.sv | 19 +
 rtl/trap_dump.sv | 104 ++++++++++
 tb/tb_trap_dump.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_dump_pkg.sv
// Shared pipeline definitions for the end-of-program memory dump.
// Holds the dump FSM state encoding and the trap instruction constant.
package trap_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  // trap 0x300 marks the end of the program
  localparam logic [0:31] TRAP_END = 32'h4400_0300;

  localparam int CNT_W = 16;

endpackage

// File: rtl/trap_dump.sv
// Spots the end-of-program trap, freezes the pipeline, lets stores retire,
// then streams DMEM[BASE_ADDR..END_ADDR) out word by word over a valid/ready port.
module trap_dump
  import trap_dump_pkg::*;
#(
  parameter logic [0:31] TRAP_WORD    = TRAP_END,
  parameter logic [31:0] BASE_ADDR    = 32'd8192,
  parameter logic [31:0] END_ADDR     = 32'd8376,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] instruction,
  output logic        halt,
  output logic        dmem_rd,
  output logic [0:31] dmem_addr,
  input  logic [0:31] dmem_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [0:31] dump_addr,
  output logic [0:31] dump_data,
  output logic        done
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
  localparam bit EMPTY = (END_ADDR <= BASE_ADDR);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      addr, addr_nx, addr_inc;
  logic [31:0]      daddr, daddr_nx;
  logic [31:0]      ddata, ddata_nx;

  assign addr_inc = addr + 32'd4;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= '0;
      daddr <= '0;
      ddata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      daddr <= daddr_nx;
      ddata <= ddata_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    daddr_nx = daddr;
    ddata_nx = ddata;
    case (state)
      S_IDLE: begin
        if (instruction == TRAP_WORD) begin
          state_nx = S_DRAIN;
          cnt_nx   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt == '0) begin
          state_nx = EMPTY ? S_DONE : S_READ;
          addr_nx  = BASE_ADDR;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_READ: state_nx = S_WAIT;
      S_WAIT: begin
        // memory answers one cycle after the read strobe
        daddr_nx = addr;
        ddata_nx = dmem_data;
        state_nx = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          if (addr_inc >= END_ADDR) begin
            state_nx = S_DONE;
          end else begin
            addr_nx  = addr_inc;
            state_nx = S_READ;
          end
        end
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign halt       = (state != S_IDLE);
  assign dmem_rd    = (state == S_READ);
  assign dmem_addr  = addr;
  assign dump_valid = (state == S_SEND);
  assign dump_addr  = daddr;
  assign dump_data  = ddata;
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_trap_dump.sv
// Bench for trap_dump: byte-array DMEM model, expected-word scoreboard,
// and a second instance configured with an empty dump range.
module tb_trap_dump;

  localparam logic [31:0] TRAP = 32'h4400_0300;
  localparam logic [31:0] BASE = 32'd8192;
  localparam logic [31:0] ENDA = 32'd8376;
  localparam int          NWORDS = 46;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [0:31] instruction = '0;
  logic        halt, dmem_rd, dump_valid, done;
  logic [0:31] dmem_addr, dump_addr, dump_data;
  logic [0:31] dmem_data = '0;
  logic        dump_ready = 1'b0;

  logic        halt2, dmem_rd2, dump_valid2, done2;
  logic [0:31] dmem_addr2, dump_addr2, dump_data2;
  logic [0:31] dmem_data2 = '0;

  logic [7:0] mem [0:65535];

  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } rec_t;
  exp_t exp_q[$];
  rec_t got_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  trap_dump dut (
    .clock(clock), .reset(reset), .instruction(instruction), .halt(halt),
    .dmem_rd(dmem_rd), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .done(done)
  );

  trap_dump #(.BASE_ADDR(32'd8192), .END_ADDR(32'd8192)) dut_empty (
    .clock(clock), .reset(reset), .instruction(instruction), .halt(halt2),
    .dmem_rd(dmem_rd2), .dmem_addr(dmem_addr2), .dmem_data(dmem_data2),
    .dump_valid(dump_valid2), .dump_ready(dump_ready), .dump_addr(dump_addr2),
    .dump_data(dump_data2), .done(done2)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [31:0] a);
    int i;
    i = int'(a[15:0]);
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  // DMEM model: big-endian word returned the cycle after the strobe
  always @(posedge clock)
    if (dmem_rd) dmem_data <= memword(dmem_addr);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    instruction = '0;
    dump_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Stimulus/collection only: issues a trap, pushes the expected words, and
  // records handshakes and strobe statistics for the calling test to judge.
  task automatic run_dump(input logic [31:0] stall_addr, input bit retrap,
                          output bit halt_nx, output int drain_n, output bit d2,
                          output int rd_total, output int rd_stall,
                          output int stable_n, output int v2_n,
                          output int post_bad, output bit timed_out);
    int stall_left;
    logic [31:0] sa, sd;
    got_q.delete();
    rd_total = 0; rd_stall = 0; stable_n = 0; v2_n = 0; post_bad = 0;
    stall_left = -1; sa = '0; sd = '0;
    for (logic [31:0] a = BASE; a < ENDA; a += 4) exp_q.push_back('{a, memword(a)});
    instruction = TRAP;
    dump_ready = 1'b1;
    @(negedge clock);
    instruction = '0;
    halt_nx = halt && !dmem_rd;
    drain_n = 0;
    while (!dmem_rd && drain_n < 50) begin
      instruction = (retrap && drain_n == 2) ? TRAP : '0;
      if (dump_valid2) v2_n++;
      @(negedge clock);
      drain_n++;
    end
    instruction = '0;
    d2 = done2 && halt2;
    for (int c = 0; c < 600 && !done; c++) begin
      if (dmem_rd) begin
        rd_total++;
        if (dmem_addr == stall_addr) rd_stall++;
      end
      if (dump_valid && dump_addr == stall_addr && stall_left < 0) begin
        stall_left = 7; sa = dump_addr; sd = dump_data;
      end
      if (stall_left > 0) begin
        dump_ready = 1'b0;
        if (dump_valid && dump_addr == sa && dump_data == sd) stable_n++;
        stall_left--;
      end else begin
        dump_ready = 1'b1;
      end
      instruction = (retrap && dump_valid && dump_addr == BASE + 8) ? TRAP : '0;
      if (dump_valid && dump_ready) got_q.push_back('{dump_addr, dump_data, c});
      if (dump_valid2) v2_n++;
      @(negedge clock);
    end
    instruction = '0;
    dump_ready = 1'b1;
    timed_out = !done;
    for (int c = 0; c < 20; c++) begin
      if (dmem_rd || dump_valid || !done || !halt || dump_valid2) post_bad++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction = TRAP;
    @(negedge clock);
    @(negedge clock);
    total_cnt++;
    if ({halt, dmem_rd, dump_valid, done} !== 4'b0) $display("FAIL reset_flags: got %b need 0000", {halt, dmem_rd, dump_valid, done});
    else pass_cnt++;
    total_cnt++;
    if (dmem_addr !== 32'd0) $display("FAIL reset_dmem_addr: got %h need 0", dmem_addr);
    else pass_cnt++;
    total_cnt++;
    if (dump_addr !== 32'd0) $display("FAIL reset_dump_addr: got %h need 0", dump_addr);
    else pass_cnt++;
    total_cnt++;
    if (dump_data !== 32'd0) $display("FAIL reset_dump_data: got %h need 0", dump_data);
    else pass_cnt++;
    total_cnt++;
    if ({halt2, dmem_rd2, dump_valid2, done2} !== 4'b0) $display("FAIL reset_empty_flags: got %b need 0000", {halt2, dmem_rd2, dump_valid2, done2});
    else pass_cnt++;
    // trap held during reset must not start a dump
    reset = 1'b0;
    instruction = '0;
    @(negedge clock);
    @(negedge clock);
    total_cnt++;
    if (halt !== 1'b0) $display("FAIL reset_priority: halt got %b need 0", halt);
    else pass_cnt++;
  endtask

  task automatic test_full_dump();
    bit hn, d2, to;
    int dn, rt, rs, st, v2, pb, bad_gap;
    exp_t e;
    rec_t g;
    exp_q.delete();
    do_reset();
    run_dump(32'hFFFF_FFFF, 1'b0, hn, dn, d2, rt, rs, st, v2, pb, to);
    total_cnt++;
    if (hn !== 1'b1) $display("FAIL full_halt_next: got %b need 1", hn);
    else pass_cnt++;
    total_cnt++;
    if (dn !== 5) $display("FAIL full_drain_len: got %0d need 5", dn);
    else pass_cnt++;
    total_cnt++;
    if (to !== 1'b0) $display("FAIL full_timeout: done never rose");
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== NWORDS) $display("FAIL full_handshakes: got %0d need %0d", got_q.size(), NWORDS);
    else pass_cnt++;
    if (got_q.size() > 0) begin
      total_cnt++;
      if (got_q[0].addr !== BASE || got_q[0].data !== 32'h2A)
        $display("FAIL full_first_word: got %h@%0d need 0000002a@8192", got_q[0].data, got_q[0].addr);
      else pass_cnt++;
    end
    bad_gap = 0;
    for (int i = 1; i < got_q.size(); i++)
      if (got_q[i].cyc - got_q[i-1].cyc != 3) bad_gap++;
    total_cnt++;
    if (bad_gap !== 0) $display("FAIL full_throughput: got %0d gaps not 3 cycles need 0", bad_gap);
    else pass_cnt++;
    total_cnt++;
    if (rt !== NWORDS) $display("FAIL full_rd_count: got %0d need %0d", rt, NWORDS);
    else pass_cnt++;
    total_cnt++;
    if (pb !== 0) $display("FAIL full_after_done: got %0d bad cycles need 0", pb);
    else pass_cnt++;
    total_cnt++;
    if (d2 !== 1'b1) $display("FAIL empty_done_after_drain: got %b need 1", d2);
    else pass_cnt++;
    total_cnt++;
    if (v2 !== 0) $display("FAIL empty_valid_cycles: got %0d need 0", v2);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (got_q.size() == 0) begin
        $display("FAIL full_word_missing: got nothing need %h@%0d", e.data, e.addr);
      end else begin
        g = got_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data)
          $display("FAIL full_word: got %h@%0d need %h@%0d", g.data, g.addr, e.data, e.addr);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit hn, d2, to;
    int dn, rt, rs, st, v2, pb, ok;
    exp_t e;
    rec_t g;
    exp_q.delete();
    do_reset();
    run_dump(BASE + 4, 1'b0, hn, dn, d2, rt, rs, st, v2, pb, to);
    total_cnt++;
    if (st !== 7) $display("FAIL bp_stable_cycles: got %0d need 7", st);
    else pass_cnt++;
    total_cnt++;
    if (rs !== 1) $display("FAIL bp_single_rd: got %0d reads of 8196 need 1", rs);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== NWORDS || rt !== NWORDS) $display("FAIL bp_counts: got %0d hs %0d rd need %0d", got_q.size(), rt, NWORDS);
    else pass_cnt++;
    ok = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) ok = 0;
      else begin
        g = got_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) ok = 0;
      end
    end
    total_cnt++;
    if (ok !== 1) $display("FAIL bp_words: got mismatched stream need exact scoreboard order");
    else pass_cnt++;
  endtask

  task automatic test_retrap_ignored();
    bit hn, d2, to;
    int dn, rt, rs, st, v2, pb, ok;
    exp_t e;
    rec_t g;
    exp_q.delete();
    do_reset();
    run_dump(32'hFFFF_FFFF, 1'b1, hn, dn, d2, rt, rs, st, v2, pb, to);
    total_cnt++;
    if (dn !== 5) $display("FAIL retrap_drain_len: got %0d need 5", dn);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== NWORDS) $display("FAIL retrap_handshakes: got %0d need %0d", got_q.size(), NWORDS);
    else pass_cnt++;
    ok = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) ok = 0;
      else begin
        g = got_q.pop_front();
        if (g.addr !== e.addr || g.data !== e.data) ok = 0;
      end
    end
    total_cnt++;
    if (ok !== 1) $display("FAIL retrap_words: got mismatched stream need exact scoreboard order");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_dump();
    bit hn, d2, to, hit;
    int dn, rt, rs, st, v2, pb;
    do_reset();
    instruction = TRAP;
    dump_ready = 1'b1;
    @(negedge clock);
    instruction = '0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (dmem_rd && dmem_addr == BASE + 8) hit = 1'b1;
      else @(negedge clock);
    end
    total_cnt++;
    if (hit !== 1'b1) $display("FAIL abort_reach_8200: got no read of 8200 need one");
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total_cnt++;
    if ({halt, dmem_rd, dump_valid, done} !== 4'b0) $display("FAIL abort_flags: got %b need 0000", {halt, dmem_rd, dump_valid, done});
    else pass_cnt++;
    total_cnt++;
    if (dmem_addr !== 32'd0 || dump_addr !== 32'd0 || dump_data !== 32'd0)
      $display("FAIL abort_regs: got %h/%h/%h need 0/0/0", dmem_addr, dump_addr, dump_data);
    else pass_cnt++;
    exp_q.delete();
    run_dump(32'hFFFF_FFFF, 1'b0, hn, dn, d2, rt, rs, st, v2, pb, to);
    total_cnt++;
    if (got_q.size() !== NWORDS) $display("FAIL abort_restart_count: got %0d need %0d", got_q.size(), NWORDS);
    else pass_cnt++;
    if (got_q.size() > 0) begin
      total_cnt++;
      if (got_q[0].addr !== BASE) $display("FAIL abort_restart_addr: got %0d need 8192", got_q[0].addr);
      else pass_cnt++;
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[8192] = 8'h00; mem[8193] = 8'h00; mem[8194] = 8'h00; mem[8195] = 8'h2A;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_retrap_ignored();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
